// File: rtl/mult_issue_ctrl_pkg.sv
// rtl/mult_issue_ctrl_pkg.sv - shared types and defaults for the multiplier issue controller
package mult_issue_ctrl_pkg;

    localparam int WIDTH_DEF = 64;
    localparam int TAG_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        BUSY,
        HOLD
    } state_t;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] a;
        logic [WIDTH_DEF-1:0] b;
        logic [TAG_W_DEF-1:0] tag;
    } req_t;

endpackage

// File: rtl/mult_issue_ctrl_if.sv
// rtl/mult_issue_ctrl_if.sv - request, multiplier and result handshakes of the issue controller
interface mult_issue_ctrl_if
    import mult_issue_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int RES_W = 2*WIDTH+1
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic [WIDTH-1:0] mul_a;
    logic [WIDTH-1:0] mul_b;
    logic             mul_start;
    logic             mul_ready;
    logic [RES_W-1:0] mul_result;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b, in_tag, mul_ready, mul_result, out_ready,
        output in_ready, mul_a, mul_b, mul_start, out_valid, out_result, out_tag, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_tag, mul_ready, mul_result, out_ready,
        input  in_ready, mul_a, mul_b, mul_start, out_valid, out_result, out_tag, busy
    );
endinterface

// File: rtl/mult_req_fifo.sv
// rtl/mult_req_fifo.sv - two-entry request FIFO; simultaneous push and pop both take effect
module mult_req_fifo
    import mult_issue_ctrl_pkg::*;
#(
    parameter type entry_t = req_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output entry_t head_o,
    output logic   full_o,
    output logic   empty_o
);
    entry_t     mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       push;
    logic       pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign push    = push_i && !full_o;
    assign pop     = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/mult_issue_ctrl.sv
// rtl/mult_issue_ctrl.sv - issues queued operand pairs to a shift-add multiplier; MULT_ISSUE_ZERO_BYPASS_EN short-circuits zero operands
module mult_issue_ctrl
    import mult_issue_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int RES_W = 2*WIDTH+1
) (
    input logic              clk,
    input logic              reset,
    mult_issue_ctrl_if.slave bus
);
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
    } req_w_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [TAG_W-1:0] tag_q;
    logic             start_q;
    logic             first_q;
    logic [RES_W-1:0] res_q;
    logic [TAG_W-1:0] otag_q;

    req_w_t in_req;
    req_w_t head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   pop;
    logic   zero_op;

    assign in_req = {bus.in_a, bus.in_b, bus.in_tag};

    mult_req_fifo #(.entry_t(req_w_t)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (bus.in_valid),
        .push_data_i (in_req),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Popping out of HOLD as the result drains gives back-to-back issue.
    assign pop = !fifo_empty &&
                 ((state_q == IDLE) || ((state_q == HOLD) && bus.out_ready));

`ifdef MULT_ISSUE_ZERO_BYPASS_EN
    assign zero_op = (head.a == '0) || (head.b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            tag_q   <= '0;
            start_q <= 1'b0;
            first_q <= 1'b0;
            res_q   <= '0;
            otag_q  <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                IDLE, HOLD: begin
                    if (pop) begin
                        a_q   <= head.a;
                        b_q   <= head.b;
                        tag_q <= head.tag;
                        if (zero_op) begin
                            res_q   <= '0;
                            otag_q  <= head.tag;
                            state_q <= HOLD;
                        end else begin
                            start_q <= 1'b1;
                            state_q <= LAUNCH;
                        end
                    end else if ((state_q == HOLD) && bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                LAUNCH: begin
                    first_q <= 1'b1;
                    state_q <= BUSY;
                end
                BUSY: begin
                    // mul_ready may still be high from the previous product here.
                    first_q <= 1'b0;
                    if (!first_q && bus.mul_ready) begin
                        res_q   <= bus.mul_result;
                        otag_q  <= tag_q;
                        state_q <= HOLD;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = !fifo_full;
    assign bus.mul_a      = a_q;
    assign bus.mul_b      = b_q;
    assign bus.mul_start  = start_q;
    assign bus.out_valid  = (state_q == HOLD);
    assign bus.out_result = res_q;
    assign bus.out_tag    = otag_q;
    assign bus.busy       = (state_q != IDLE) || !fifo_empty;
endmodule

// File: doc/mult_issue_ctrl.md
MULT_ISSUE_CTRL -- requirements
Module: mult_issue_ctrl

Interface
REQ-001 SHALL have parameters: WIDTH, 64, operand width; TAG_W, 4, request tag width; RES_W, 2*WIDTH+1 (129), product width.
REQ-002 SHALL have ports (one clock; reset asynchronous, active-high):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operand request valid
- in_ready  out  1  request accepted when in_valid&in_ready
- in_a, in_b  in  WIDTH  multiplicand, multiplier
- in_tag  in  TAG_W  request tag
- mul_a, mul_b  out  WIDTH  operands to shift-add multiplier (a_in, b_in)
- mul_start  out  1  one-cycle start pulse to multiplier
- mul_ready  in  1  multiplier done level
- mul_result  in  RES_W  multiplier product
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts when out_valid&out_ready
- out_result  out  RES_W  product
- out_tag  out  TAG_W  tag of the request that produced out_result
- busy  out  1  high whenever FSM is not IDLE or the queue is non-empty

Function
REQ-003 SHALL buffer requests in a 2-entry FIFO of {a,b,tag}; in_ready = FIFO not full; a push and a pop in the same cycle SHALL both take effect.
REQ-004 SHALL run FSM IDLE -> LAUNCH -> BUSY -> HOLD -> IDLE.
REQ-005 IDLE: when the FIFO is non-empty and the output register is empty (or drained this cycle), SHALL pop the head into operand registers and go to LAUNCH.
REQ-006 LAUNCH: SHALL assert mul_start for exactly one cycle; mul_a/mul_b SHALL be stable from LAUNCH until HOLD exits; next state BUSY.
REQ-007 BUSY: SHALL ignore mul_ready in the first BUSY cycle; thereafter, when mul_ready=1, SHALL capture mul_result and the tag into the output register and go to HOLD.
REQ-008 HOLD: out_valid=1; on out_ready=1 SHALL go to IDLE, and SHALL pop the next entry in that same cycle if one is present (back-to-back issue with no idle cycle).
REQ-009 out_result/out_tag SHALL NOT change while out_valid=1 and out_ready=0.
REQ-010 Latency from acceptance into an empty FIFO with idle FSM: mul_start 2 cycles later; out_valid 1 cycle after the first qualifying mul_ready.
REQ-011 Results SHALL be returned in request order; no request SHALL be dropped or duplicated.
REQ-012 in_valid while full SHALL have no effect (in_ready=0); out_ready while out_valid=0 SHALL be ignored.

Reset
REQ-013 reset SHALL asynchronously force: FSM=IDLE, FIFO empty, in_ready=1, mul_start=0, out_valid=0, busy=0, and mul_a, mul_b, out_result, out_tag=0.
REQ-014 reset asserted mid-operation SHALL discard all queued and in-flight requests; the multiplier is reset by the same signal.

Configuration
REQ-015 Macro MULT_ISSUE_ZERO_BYPASS_EN: when defined, a popped request with in_a==0 or in_b==0 SHALL skip LAUNCH/BUSY, present out_result=0 with its tag in HOLD on the next cycle, and never pulse mul_start.
REQ-016 Without the macro, every request SHALL go through the multiplier.

Structure
REQ-017 A shared package SHALL hold the FSM state enum {IDLE, LAUNCH, BUSY, HOLD}, the WIDTH/TAG_W defaults, and a request struct {a,b,tag}.
REQ-018 The 2-entry FIFO SHALL be a sub-module named mult_req_fifo; the FSM and output register SHALL stay in mult_issue_ctrl.

Verification
REQ-019 The bench SHALL pair the block with the shift-add multiplier and cover these scenarios:
- Single request a=3, b=5, tag=1, out_ready=1 -> one mul_start pulse; out_result=15, out_tag=1.
- Requests (0xFFFF_FFFF_FFFF_FFFF × 2, tag 2) then (7×9, tag 3) sent back-to-back -> results 0x1_FFFF_FFFF_FFFF_FFFE/tag 2, then 63/tag 3; in_ready drops when 2 entries are queued.
- out_ready held 0 for 20 cycles during HOLD -> out_result/out_tag stable, no second mul_start; the next request launches in the same cycle out_ready rises.
- reset pulsed in BUSY with 1 entry queued -> all outputs at reset values immediately; after release, a new request 4×4 returns 16.
- With MULT_ISSUE_ZERO_BYPASS_EN: request 0×123, tag 5 -> out_result=0, tag 5, no mul_start; without the macro, the same request -> mul_start pulses and out_result=0.
